// File: rtl/life_pkg.sv
// Shared definitions for the Game of Life blocks: board geometry defaults,
// frame sync marker and the loader FSM state encoding.
package life_pkg;

    localparam int         N_ROWS_DEFAULT    = 8;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } life_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/life_timeout.sv
// Saturating idle-cycle counter; expired flags the cycle on which the count
// sits at its limit while counting is enabled.
module life_timeout
    import life_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            CW    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_r;

    // Idle counter: cleared on demand, holds at the limit instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= {CW{1'b0}};
        end else if (clear) begin
            count_r <= {CW{1'b0}};
        end else if (enable && (count_r != LIMIT)) begin
            count_r <= count_r + CW'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LIMIT);

endmodule

// File: rtl/life_pattern_loader.sv
// Assembles sync-prefixed byte streams into a full board and hands it to the
// game core with a valid/ready handshake; stalled frames are dropped.
module life_pattern_loader
    import life_pkg::*;
#(
    parameter int         N_ROWS         = N_ROWS_DEFAULT,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [8*N_ROWS-1:0]   board,
    output logic                  board_valid,
    input  logic                  board_ready,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int            RW       = cnt_width(N_ROWS);
    localparam logic [RW-1:0] LAST_ROW = RW'(N_ROWS - 1);

    life_state_t           state_r;
    life_state_t           state_nxt_s;
    logic [RW-1:0]         row_cnt_r;
    logic [RW-1:0]         row_cnt_nxt_s;
    logic [8*N_ROWS-1:0]   shadow_r;
    logic [8*N_ROWS-1:0]   shadow_nxt_s;
    logic [8*N_ROWS-1:0]   board_r;
    logic                  board_valid_r;
    logic                  frame_err_r;
    logic                  frame_err_nxt_s;
    logic                  busy_r;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  tmo_clear_s;
    logic                  tmo_enable_s;
    logic                  timeout_s;

    // Ready is forced low during reset so no byte slips in before the FSM is sane.
    assign in_ready_s   = rst && (state_r != ST_COMMIT);
    assign accept_s     = in_valid && in_ready_s;
    assign tmo_enable_s = (state_r == ST_COLLECT);
    assign tmo_clear_s  = !tmo_enable_s || accept_s;

    life_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear_s),
        .enable  (tmo_enable_s),
        .expired (timeout_s)
    );

    // Next-state, row capture and drop detection; an accepted byte beats the timeout.
    always_comb begin
        state_nxt_s     = state_r;
        row_cnt_nxt_s   = row_cnt_r;
        shadow_nxt_s    = shadow_r;
        frame_err_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && (in_data == SYNC_BYTE)) begin
                    state_nxt_s   = ST_COLLECT;
                    row_cnt_nxt_s = {RW{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (accept_s) begin
                    shadow_nxt_s[8*int'(row_cnt_r) +: 8] = in_data;
                    if (row_cnt_r == LAST_ROW) begin
                        state_nxt_s   = ST_COMMIT;
                        row_cnt_nxt_s = {RW{1'b0}};
                    end else begin
                        row_cnt_nxt_s = row_cnt_r + RW'(1'b1);
                    end
                end else if (timeout_s) begin
                    state_nxt_s     = ST_IDLE;
                    row_cnt_nxt_s   = {RW{1'b0}};
                    frame_err_nxt_s = 1'b1;
                end else begin
                    state_nxt_s     = ST_COLLECT;
                end
            end
            ST_COMMIT: begin
                if (board_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_COMMIT;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                row_cnt_nxt_s = {RW{1'b0}};
            end
        endcase
    end

    // State and output registers; board only reloads when a frame completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            row_cnt_r     <= {RW{1'b0}};
            shadow_r      <= {(8*N_ROWS){1'b0}};
            board_r       <= {(8*N_ROWS){1'b0}};
            board_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            row_cnt_r     <= row_cnt_nxt_s;
            shadow_r      <= shadow_nxt_s;
            board_valid_r <= (state_nxt_s == ST_COMMIT);
            frame_err_r   <= frame_err_nxt_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
            if ((state_r == ST_COLLECT) && (state_nxt_s == ST_COMMIT)) begin
                board_r <= shadow_nxt_s;
            end else begin
                board_r <= board_r;
            end
        end
    end

    assign in_ready    = in_ready_s;
    assign board       = board_r;
    assign board_valid = board_valid_r;
    assign frame_err   = frame_err_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_life_pattern_loader.sv
// Directed bench for life_pattern_loader: frame load, garbage rejection,
// backpressure, timeout boundary, mid-frame reset and in-frame sync data.
module tb_life_pattern_loader;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] board;
    logic        board_valid;
    logic        board_ready;
    logic        frame_err;
    logic        busy;

    int checks  = 0;
    int fails   = 0;
    int err_cnt = 0;

    life_pattern_loader #(
        .N_ROWS         (8),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .board       (board),
        .board_valid (board_valid),
        .board_ready (board_ready),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; board_ready = 1'b0;
        repeat (2) tick();
        checks++; if (board !== 64'h0) begin fails++; $display("FAIL reset_board: got %h want 0", board); end
        checks++; if (board_valid !== 1'b0) begin fails++; $display("FAIL reset_board_valid: got %b want 0", board_valid); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0] seq [9];
        seq = '{8'hA5, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        board_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            checks++; if (board_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid[%0d]: got %b want 0", i, board_valid); end
            drive_byte(seq[i]);
        end
        in_valid = 1'b0;
        checks++; if (board_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: got %b want 1", board_valid); end
        checks++; if (board !== 64'h8040201008040201) begin fails++; $display("FAIL basic_board: got %h want 8040201008040201", board); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL basic_commit_ready: got %b want 0", in_ready); end
        tick();
        checks++; if (board_valid !== 1'b0) begin fails++; $display("FAIL basic_valid_drop: got %b want 0", board_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b want 0", busy); end
        checks++; if (board !== 64'h8040201008040201) begin fails++; $display("FAIL basic_board_hold: got %h want 8040201008040201", board); end
    endtask

    task automatic test_garbage();
        int e0;
        e0 = err_cnt;
        board_ready = 1'b1;
        drive_byte(8'h00);
        drive_byte(8'hFF);
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL garbage_busy: got %b want 0", busy); end
        drive_byte(8'hA5);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL garbage_sync_busy: got %b want 1", busy); end
        repeat (8) drive_byte(8'hFF);
        in_valid = 1'b0;
        checks++; if (board_valid !== 1'b1) begin fails++; $display("FAIL garbage_valid: got %b want 1", board_valid); end
        checks++; if (board !== 64'hFFFFFFFFFFFFFFFF) begin fails++; $display("FAIL garbage_board: got %h want all ones", board); end
        tick();
        checks++; if (err_cnt !== e0) begin fails++; $display("FAIL garbage_frame_err: got %0d pulses want 0", err_cnt - e0); end
    endtask

    task automatic test_backpressure();
        logic [7:0] seq [9];
        seq = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        board_ready = 1'b0;
        for (int i = 0; i < 9; i++) drive_byte(seq[i]);
        in_data = 8'h5A;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (board_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b want 1", i, board_valid); end
            checks++; if (board !== 64'h8877665544332211) begin fails++; $display("FAIL bp_board[%0d]: got %h want 8877665544332211", i, board); end
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
        end
        board_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        checks++; if (board_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid: got %b want 0", board_valid); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        logic [7:0] seq [9];
        seq = '{8'hA5, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
        board_ready = 1'b1;
        drive_byte(8'hA5);
        drive_byte(8'h33);
        in_valid = 1'b0;
        repeat (TO - 1) tick();
        drive_byte(8'h44);
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL tmo_boundary_busy: got %b want 1", busy); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL tmo_boundary_err: got %b want 0", frame_err); end
        drive_byte(8'h55);
        in_valid = 1'b0;
        repeat (TO - 1) tick();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL tmo_early_busy: got %b want 1", busy); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL tmo_early_err: got %b want 0", frame_err); end
        tick();
        checks++; if (frame_err !== 1'b1) begin fails++; $display("FAIL tmo_err_pulse: got %b want 1", frame_err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL tmo_busy: got %b want 0", busy); end
        checks++; if (board_valid !== 1'b0) begin fails++; $display("FAIL tmo_valid: got %b want 0", board_valid); end
        checks++; if (board !== 64'h8877665544332211) begin fails++; $display("FAIL tmo_board_hold: got %h want 8877665544332211", board); end
        tick();
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL tmo_err_width: got %b want 0", frame_err); end
        for (int i = 0; i < 9; i++) drive_byte(seq[i]);
        in_valid = 1'b0;
        checks++; if (board !== 64'hFF7F3F1F0F070301) begin fails++; $display("FAIL tmo_reload_board: got %h want FF7F3F1F0F070301", board); end
        checks++; if (board_valid !== 1'b1) begin fails++; $display("FAIL tmo_reload_valid: got %b want 1", board_valid); end
        tick();
    endtask

    task automatic test_reset_mid();
        int e0;
        logic [7:0] seq [9];
        seq = '{8'hA5, 8'h10, 8'h20, 8'hA5, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
        board_ready = 1'b1;
        for (int i = 0; i < 5; i++) drive_byte(seq[i]);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++; if (board !== 64'h0) begin fails++; $display("FAIL rmid_board: got %h want 0", board); end
        checks++; if (board_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", board_valid); end
        checks++; if (frame_err !== 1'b0) begin fails++; $display("FAIL rmid_err: got %b want 0", frame_err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
        e0 = err_cnt;
        rst = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) drive_byte(seq[i]);
        in_valid = 1'b0;
        checks++; if (board !== 64'h8070605040A52010) begin fails++; $display("FAIL rmid_reload_board: got %h want 8070605040A52010", board); end
        checks++; if (board[23:16] !== 8'hA5) begin fails++; $display("FAIL sync_as_data: got %h want a5", board[23:16]); end
        repeat (3) tick();
        checks++; if (err_cnt !== e0) begin fails++; $display("FAIL rmid_no_err: got %0d pulses want 0", err_cnt - e0); end
        checks++; if (board_valid !== 1'b0) begin fails++; $display("FAIL rmid_final_valid: got %b want 0", board_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_garbage();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
